mem_responder: RTL and testbench



---
 rtl/mem_responder_pkg.sv | 19 +
 rtl/lane_decode.sv | 47 ++++
 rtl/mem_responder.sv | 151 +++++++++++++++
 tb/tb_mem_responder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared size and FSM state encodings for mem_responder
package mem_responder_pkg;

    // Access size as presented on the size port
    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    // Responder FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/lane_decode.sv
// rtl/lane_decode.sv - size/offset to byte-enable, lane-shifted write word and misalign flag
//
// Ports:
//   size      - access size (SZ_WORD / SZ_HALF / SZ_BYTE / reserved)
//   addr_lo   - addr[1:0], byte offset inside the word
//   wdata     - right-aligned store data
//   be        - byte enables, bit k selects word bits [8k+7:8k]
//   wword     - store data replicated so every enabled lane carries its byte
//   misalign  - halfword on odd address or word not on a word boundary
module lane_decode
    import mem_responder_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic        misalign
);

    always_comb begin
        be       = 4'b0000;
        wword    = 32'h0;
        misalign = 1'b0;
        case (size)
            SZ_WORD: begin
                be       = 4'b1111;
                wword    = wdata;
                misalign = (addr_lo != 2'b00);
            end
            SZ_HALF: begin
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword    = {2{wdata[15:0]}};
                misalign = addr_lo[0];
            end
            SZ_BYTE: begin
                be       = 4'b0001 << addr_lo;
                wword    = {4{wdata[7:0]}};
            end
            default: begin
                // Reserved size: no lanes; the top flags it as an error on its own
                be       = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency single-port byte-addressed memory responder
//
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-low reset
//   req    - request, held until ready
//   we     - 1 store, 0 load
//   size   - 00 word, 01 half, 10 byte, 11 reserved
//   addr   - byte address
//   wdata  - right-aligned store data
//   ready  - one-cycle response strobe
//   rdata  - aligned word containing addr (loads only, 0 on error)
//   err    - misaligned, reserved size or out-of-range access
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          we_q;
    logic [1:0]    size_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          ready_q;
    logic          err_q;
    logic [31:0]   rdata_q;

    logic [31:0]   mem_q [WORDS];

    // In IDLE the live inputs are the request being accepted (needed when
    // WAIT_CYCLES=0 jumps straight to RESP); afterwards only captured values count.
    logic          idle;
    logic          eff_we;
    logic [1:0]    eff_size;
    logic [31:0]   eff_addr;
    logic [31:0]   eff_wdata;
    logic [3:0]    be;
    logic [31:0]   wword;
    logic          misalign;
    logic          bad_d;
    logic [IW-1:0] word_idx;
    logic [31:0]   rdata_d;

    assign idle      = (state_q == S_IDLE);
    assign eff_we    = idle ? we    : we_q;
    assign eff_size  = idle ? size  : size_q;
    assign eff_addr  = idle ? addr  : addr_q;
    assign eff_wdata = idle ? wdata : wdata_q;

    lane_decode u_lane_decode (
        .size     (eff_size),
        .addr_lo  (eff_addr[1:0]),
        .wdata    (eff_wdata),
        .be       (be),
        .wword    (wword),
        .misalign (misalign)
    );

    assign bad_d    = misalign || (eff_size == SZ_RSVD) || (|eff_addr[31:AW]);
    assign word_idx = eff_addr[2 +: IW];
    assign rdata_d  = (bad_d || eff_we) ? 32'h0 : mem_q[word_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        size_q  <= size;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= S_RESP;
                            ready_q <= 1'b1;
                            err_q   <= bad_d;
                            rdata_q <= rdata_d;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= CW'(WAIT_CYCLES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= S_RESP;
                        ready_q <= 1'b1;
                        err_q   <= bad_d;
                        rdata_q <= rdata_d;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Store commits on the edge leaving RESP; a reset forces IDLE first, so an
    // abandoned request never writes. The array itself is never cleared.
    always_ff @(posedge clk) begin
        if (state_q == S_RESP && we_q && !err_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[word_idx][8*i +: 8] <= wword[8*i +: 8];
                end
            end
        end
    end

    assign ready = ready_q;
    assign err   = err_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder with a byte-array reference model
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        req = 1'b0, we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        ready, err;
    logic [31:0] rdata;

    logic        req0 = 1'b0, we0 = 1'b0;
    logic [1:0]  size0 = 2'b00;
    logic [31:0] addr0 = 32'h0, wdata0 = 32'h0;
    logic        ready0, err0;
    logic [31:0] rdata0;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] mdl [256];

    always #5 clk = ~clk;

    mem_responder #(.WAIT_CYCLES(2), .DEPTH_BYTES(256)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
        .addr(addr), .wdata(wdata), .ready(ready), .rdata(rdata), .err(err)
    );

    mem_responder #(.WAIT_CYCLES(0), .DEPTH_BYTES(256)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we0), .size(size0),
        .addr(addr0), .wdata(wdata0), .ready(ready0), .rdata(rdata0), .err(err0)
    );

    // Reference model: legality and byte-array semantics straight from the access rules
    function automatic logic model_err(input logic [1:0] s, input logic [31:0] a);
        if (s == 2'b11) return 1'b1;
        if (a >= 32'd256) return 1'b1;
        if (s == 2'b01 && (a % 2) != 0) return 1'b1;
        if (s == 2'b00 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int base;
        base = int'(a) / 4 * 4;
        return {mdl[base+3], mdl[base+2], mdl[base+1], mdl[base]};
    endfunction

    function automatic void model_store(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        int n;
        if (model_err(s, a)) return;
        n = (s == 2'b00) ? 4 : (s == 2'b01) ? 2 : 1;
        for (int k = 0; k < n; k++) mdl[int'(a) + k] = d[8*k +: 8];
    endfunction

    task automatic do_req(input logic w, input logic [1:0] s, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output logic e,
                          output int lat);
        logic found;
        @(negedge clk);
        req = 1'b1; we = w; size = s; addr = a; wdata = d;
        @(posedge clk);
        lat = 1;
        #1;
        req = 1'b0; we = 1'($urandom); size = 2'($urandom);
        addr = $urandom; wdata = $urandom;
        rd = 32'h0; e = 1'b0; found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (ready) begin
                rd = rdata; e = err; found = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        if (!found) lat = 99;
        @(posedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #1;
        tests_run++;
        if (ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready got %b want 0", ready); end
        tests_run++;
        if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err got %b want 0", err); end
        tests_run++;
        if (rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata got %h want 0", rdata); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_fill;
        logic [31:0] rd, d;
        logic e;
        int lat;
        for (int i = 0; i < 64; i++) begin
            d = $urandom;
            do_req(1'b1, 2'b00, 32'(i * 4), d, rd, e, lat);
            model_store(2'b00, 32'(i * 4), d);
            tests_run++;
            if (e !== 1'b0 || lat != 3) begin
                tests_failed++;
                $display("FAIL fill[%0d] err=%b lat=%0d want err=0 lat=3", i, e, lat);
            end
        end
    endtask

    task automatic test_directed;
        logic [31:0] rd;
        logic e;
        int lat;
        do_req(1'b1, 2'b00, 32'h10, 32'hDEADBEEF, rd, e, lat);
        model_store(2'b00, 32'h10, 32'hDEADBEEF);
        tests_run++;
        if (e !== 1'b0 || lat != 3) begin tests_failed++; $display("FAIL st_word err=%b lat=%0d want 0/3", e, lat); end
        @(negedge clk);
        tests_run++;
        if (ready !== 1'b0 || rdata !== 32'h0) begin
            tests_failed++; $display("FAIL pulse_width ready=%b rdata=%h want 0/0", ready, rdata);
        end
        do_req(1'b0, 2'b00, 32'h10, 32'h0, rd, e, lat);
        tests_run++;
        if (rd !== 32'hDEADBEEF || e !== 1'b0 || lat != 3) begin
            tests_failed++; $display("FAIL ld_word rdata=%h err=%b lat=%0d want deadbeef/0/3", rd, e, lat);
        end
        do_req(1'b1, 2'b10, 32'h12, 32'h000000AA, rd, e, lat);
        model_store(2'b10, 32'h12, 32'hAA);
        do_req(1'b0, 2'b10, 32'h10, 32'h0, rd, e, lat);
        tests_run++;
        if (rd !== 32'hDEAABEEF || e !== 1'b0) begin
            tests_failed++; $display("FAIL st_byte rdata=%h err=%b want deaabeef/0", rd, e);
        end
        do_req(1'b1, 2'b01, 32'h11, 32'h00001234, rd, e, lat);
        tests_run++;
        if (e !== 1'b1 || lat != 3) begin tests_failed++; $display("FAIL half_misalign err=%b lat=%0d want 1/3", e, lat); end
        do_req(1'b0, 2'b00, 32'h10, 32'h0, rd, e, lat);
        tests_run++;
        if (rd !== 32'hDEAABEEF) begin tests_failed++; $display("FAIL half_suppressed rdata=%h want deaabeef", rd); end
        do_req(1'b0, 2'b00, 32'h100, 32'h0, rd, e, lat);
        tests_run++;
        if (e !== 1'b1 || rd !== 32'h0) begin
            tests_failed++; $display("FAIL out_of_range err=%b rdata=%h want 1/0", e, rd);
        end
        do_req(1'b0, 2'b11, 32'h20, 32'h0, rd, e, lat);
        tests_run++;
        if (e !== 1'b1 || rd !== 32'h0) begin
            tests_failed++; $display("FAIL rsvd_size err=%b rdata=%h want 1/0", e, rd);
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, a, d, exp_rd;
        logic [1:0] s;
        logic w, e, exp_e;
        int lat;
        for (int i = 0; i < 300; i++) begin
            w = 1'($urandom);
            s = 2'($urandom);
            a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 259));
            d = $urandom;
            exp_e = model_err(s, a);
            exp_rd = (exp_e || w) ? 32'h0 : model_word(a);
            do_req(w, s, a, d, rd, e, lat);
            if (w) model_store(s, a, d);
            tests_run++;
            if (e !== exp_e || lat != 3 || (!w && rd !== exp_rd)) begin
                tests_failed++;
                $display("FAIL rand[%0d] we=%b sz=%0d a=%h err=%b lat=%0d rdata=%h want err=%b lat=3 rdata=%h",
                         i, w, s, a, e, lat, rd, exp_e, exp_rd);
            end
        end
    endtask

    task automatic test_reset_abort;
        logic [31:0] rd, old;
        logic e;
        int lat;
        old = model_word(32'h20);
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h20; wdata = ~old;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests_run++;
        if (ready !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin
            tests_failed++; $display("FAIL abort_wait_outputs ready=%b err=%b rdata=%h want 0", ready, err, rdata);
        end
        @(negedge clk);
        reset = 1'b1;
        do_req(1'b0, 2'b00, 32'h20, 32'h0, rd, e, lat);
        tests_run++;
        if (rd !== old || e !== 1'b0 || lat != 3) begin
            tests_failed++; $display("FAIL abort_wait_load rdata=%h err=%b lat=%0d want %h/0/3", rd, e, lat, old);
        end
        // Reset while the response is on the bus: outputs drop at once, no write
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h20; wdata = ~old;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (ready !== 1'b1) begin tests_failed++; $display("FAIL abort_resp_ready got %b want 1", ready); end
        reset = 1'b0;
        #1;
        tests_run++;
        if (ready !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin
            tests_failed++; $display("FAIL abort_resp_outputs ready=%b err=%b rdata=%h want 0", ready, err, rdata);
        end
        @(negedge clk);
        reset = 1'b1;
        do_req(1'b0, 2'b00, 32'h20, 32'h0, rd, e, lat);
        tests_run++;
        if (rd !== old) begin tests_failed++; $display("FAIL abort_resp_load rdata=%h want %h", rd, old); end
    endtask

    task automatic test_back_to_back;
        logic exp_r;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; size0 = 2'b00; addr0 = 32'h0; wdata0 = 32'hCAFEF00D;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_r = (k % 2 == 0);
            tests_run++;
            if (ready0 !== exp_r || err0 !== 1'b0) begin
                tests_failed++; $display("FAIL b2b[%0d] ready=%b err=%b want %b/0", k, ready0, err0, exp_r);
            end
        end
        req0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req0 = 1'b0;
        tests_run++;
        if (ready0 !== 1'b1 || rdata0 !== 32'hCAFEF00D) begin
            tests_failed++; $display("FAIL b2b_load ready=%b rdata=%h want 1/cafef00d", ready0, rdata0);
        end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_directed;
        test_random;
        test_reset_abort;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
